// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants used by the writeback stage and register file.
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA = 5'd31;
  localparam logic [31:0] NOP_IR = 32'h0;
endpackage

// File: rtl/grf_core.sv
// General register file: synchronous write and clear, two combinational read
// ports that see a same-cycle write (bypass). Entry 0 is hardwired to zero.
module grf_core #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  import mips_pkg::*;

  localparam int N_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [N_REGS];
  logic              wr_ok;

  assign wr_ok = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < N_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[waddr] <= wdata;
    end
  end

  // Zero check comes first so entry 0 reads 0 regardless of what is on the write port.
  always_comb begin
    rdata1 = regs[raddr1];
    if (raddr1 == '0) begin
      rdata1 = '0;
    end else if (wr_ok && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (raddr2 == '0) begin
      rdata2 = '0;
    end else if (wr_ok && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
  end
endmodule

// File: rtl/wb_grf.sv
// W-stage writeback: destination/data mux, register file, forwarding outputs and
// retired-instruction counter. Define GRF_WRITE_LOG_EN for a per-write simulation log.
module wb_grf #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       IR_W,
  input  logic [31:0]       PC4_W,
  input  logic [DATA_W-1:0] AO_W,
  input  logic [DATA_W-1:0] DM_W,
  input  logic              lw_W,
  input  logic              r_t_W,
  input  logic              grf_we_W,
  input  logic [ADDR_W-1:0] grf_rt_W,
  input  logic [ADDR_W-1:0] grf_rd_W,
  input  logic [ADDR_W-1:0] A1_D,
  input  logic [ADDR_W-1:0] A2_D,
  output logic [DATA_W-1:0] RD1_D,
  output logic [DATA_W-1:0] RD2_D,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_cnt
);
  import mips_pkg::*;

  logic [ADDR_W-1:0] dst;
  logic [DATA_W-1:0] wd;

  assign dst     = r_t_W ? grf_rt_W : grf_rd_W;
  assign wd      = lw_W ? DM_W : AO_W;
  assign wb_we   = grf_we_W && (dst != '0);
  assign wb_addr = wb_we ? dst : '0;
  assign wb_data = wb_we ? wd : '0;

  grf_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_grf_core (
    .clk    (clk),
    .clr    (clr),
    .we     (wb_we),
    .waddr  (dst),
    .wdata  (wd),
    .raddr1 (A1_D),
    .raddr2 (A2_D),
    .rdata1 (RD1_D),
    .rdata2 (RD2_D)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      retire_cnt <= '0;
    end else if (IR_W != NOP_IR) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

`ifdef GRF_WRITE_LOG_EN
  always_ff @(posedge clk) begin
    if (!clr && wb_we) begin
      $display("%0t@%08h: $%2d <= %08h", $time, PC4_W - 32'd4, dst, wd);
    end
  end
`else
  logic unused_pc4;
  assign unused_pc4 = ^PC4_W;
`endif
endmodule
